cpu_controller: RTL

Moore control FSM for the 16-bit SimpleRISC CPU, sitting directly downstream of the instruction decoder. It consumes the decoder's `opcode`, `op` and `cond` fields, plus the status flags. It sequences fetch, decode and execute by driving the datapath, register file, PC and memory strobes, and the one-hot `nsel` select that the decoder turns into `readnum`/`writenum`.

---
 rtl/cpu_pkg.sv | 90 +++++++++
 rtl/cond_eval.sv | 25 ++
 rtl/cpu_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the SimpleRISC control path: FSM states, instruction fields and mux selects.
// Branch-only states and encodings exist only when CPU_BRANCH_EN is defined.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPD,
        S_DEC,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_C,
        S_CMP,
        S_ADDR,
        S_LD_ADDR,
        S_MEM_RD,
        S_WR_M,
        S_GET_RD,
        S_PASS,
        S_MEM_WR,
        S_HALT
`ifdef CPU_BRANCH_EN
        ,
        S_BR,
        S_LINK_BL,
        S_LINK_BLX,
        S_JMP
`endif
    } state_t;

    // Which execute path an instruction follows once the shared states diverge.
    typedef enum logic [2:0] {
        C_MOV,
        C_ALU,
        C_CMP,
        C_LDR,
        C_STR
`ifdef CPU_BRANCH_EN
        ,
        C_JMP
`endif
    } iclass_t;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] PC_SEL_INC = 2'b00;

    localparam logic [1:0] MEM_CMD_NONE  = 2'b00;
    localparam logic [1:0] MEM_CMD_READ  = 2'b01;
    localparam logic [1:0] MEM_CMD_WRITE = 2'b10;

`ifdef CPU_BRANCH_EN
    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_CALL = 3'b010;

    localparam logic [1:0] OP_B   = 2'b00;
    localparam logic [1:0] OP_BL  = 2'b11;
    localparam logic [1:0] OP_BX  = 2'b00;
    localparam logic [1:0] OP_BLX = 2'b10;

    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] PC_SEL_REL = 2'b01;
    localparam logic [1:0] PC_SEL_C   = 2'b10;
`endif

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides from cond and the Z/N/V flags whether a B<cond> is taken.
// Only built with CPU_BRANCH_EN; without it the controller has no branches to evaluate.
`ifdef CPU_BRANCH_EN
module cond_eval (
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = Z;
            3'b010:  taken = !Z;
            3'b011:  taken = N ^ V;
            3'b100:  taken = (N ^ V) | Z;
            default: taken = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/cpu_controller.sv
// Moore control FSM for the SimpleRISC CPU: fetch, decode and execute sequencing.
// Define CPU_BRANCH_EN to add B<cond>, BL, BX and BLX; otherwise opcodes 001/010 halt.
module cpu_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halt
);

    import cpu_pkg::*;

    state_t  state, state_nxt;
    iclass_t cls, cls_nxt;

`ifdef CPU_BRANCH_EN
    logic taken;

    cond_eval u_cond_eval (
        .cond  (cond),
        .Z     (Z),
        .N     (N),
        .V     (V),
        .taken (taken)
    );
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{cond, Z, N, V};
`endif

    // cls is captured in DEC so later states never re-read the instruction fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
            cls   <= C_MOV;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt = state;
        cls_nxt   = cls;
        case (state)
            S_RST: state_nxt = S_IF1;
            S_IF1: state_nxt = S_IF2;
            S_IF2: state_nxt = S_UPD;
            S_UPD: state_nxt = S_DEC;
            S_DEC: begin
                state_nxt = S_HALT;
                case (opcode)
                    OPC_MOV: begin
                        if (op == OP_MOV_IMM) begin
                            state_nxt = S_WR_IMM;
                        end else if (op == OP_MOV_REG) begin
                            state_nxt = S_GET_B;
                            cls_nxt   = C_MOV;
                        end
                    end
                    OPC_ALU: begin
                        case (op)
                            OP_ADD, OP_AND: begin
                                state_nxt = S_GET_A;
                                cls_nxt   = C_ALU;
                            end
                            OP_CMP: begin
                                state_nxt = S_GET_A;
                                cls_nxt   = C_CMP;
                            end
                            OP_MVN: begin
                                state_nxt = S_GET_B;
                                cls_nxt   = C_ALU;
                            end
                            default: state_nxt = S_HALT;
                        endcase
                    end
                    OPC_LDR: begin
                        if (op == OP_MEM) begin
                            state_nxt = S_GET_A;
                            cls_nxt   = C_LDR;
                        end
                    end
                    OPC_STR: begin
                        if (op == OP_MEM) begin
                            state_nxt = S_GET_A;
                            cls_nxt   = C_STR;
                        end
                    end
`ifdef CPU_BRANCH_EN
                    OPC_B: begin
                        if (op == OP_B) state_nxt = taken ? S_BR : S_IF1;
                    end
                    OPC_CALL: begin
                        case (op)
                            OP_BL: state_nxt = S_LINK_BL;
                            OP_BX: begin
                                state_nxt = S_GET_RD;
                                cls_nxt   = C_JMP;
                            end
                            OP_BLX: begin
                                state_nxt = S_LINK_BLX;
                                cls_nxt   = C_JMP;
                            end
                            default: state_nxt = S_HALT;
                        endcase
                    end
`endif
                    OPC_HALT: state_nxt = S_HALT;
                    default:  state_nxt = S_HALT;
                endcase
            end
            S_GET_A:   state_nxt = (cls == C_LDR || cls == C_STR) ? S_ADDR : S_GET_B;
            S_GET_B: begin
                if (cls == C_MOV)      state_nxt = S_PASS;
                else if (cls == C_CMP) state_nxt = S_CMP;
                else                   state_nxt = S_ALU;
            end
            S_ALU:     state_nxt = S_WR_C;
            S_ADDR:    state_nxt = S_LD_ADDR;
            S_LD_ADDR: state_nxt = (cls == C_LDR) ? S_MEM_RD : S_GET_RD;
            S_MEM_RD:  state_nxt = S_WR_M;
            S_GET_RD:  state_nxt = S_PASS;
            S_PASS: begin
                case (cls)
                    C_MOV:   state_nxt = S_WR_C;
                    C_STR:   state_nxt = S_MEM_WR;
`ifdef CPU_BRANCH_EN
                    C_JMP:   state_nxt = S_JMP;
`endif
                    default: state_nxt = S_HALT;
                endcase
            end
            S_WR_IMM, S_WR_C, S_CMP, S_WR_M, S_MEM_WR: state_nxt = S_IF1;
            S_HALT:    state_nxt = S_HALT;
`ifdef CPU_BRANCH_EN
            S_BR, S_JMP: state_nxt = S_IF1;
            S_LINK_BL:   state_nxt = S_BR;
            S_LINK_BLX:  state_nxt = S_GET_RD;
`endif
            default:   state_nxt = S_RST;
        endcase
    end

    always_comb begin
        nsel      = NSEL_NONE;
        vsel      = VSEL_C;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        write     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        pc_sel    = PC_SEL_INC;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MEM_CMD_NONE;
        halt      = 1'b0;
        case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_CMD_READ;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_CMD_READ;
                load_ir  = 1'b1;
            end
            S_UPD: begin
                load_pc = 1'b1;
                pc_sel  = PC_SEL_INC;
            end
            S_WR_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: loadc = 1'b1;
            S_WR_C: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_CMP: loads = 1'b1;
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LD_ADDR: load_addr = 1'b1;
            S_MEM_RD:  mem_cmd = MEM_CMD_READ;
            S_WR_M: begin
                mem_cmd = MEM_CMD_READ;
                nsel    = NSEL_RD;
                vsel    = VSEL_MDATA;
                write   = 1'b1;
            end
            S_GET_RD: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_PASS: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEM_WR: mem_cmd = MEM_CMD_WRITE;
            S_HALT:   halt = 1'b1;
`ifdef CPU_BRANCH_EN
            S_BR: begin
                load_pc = 1'b1;
                pc_sel  = PC_SEL_REL;
            end
            S_LINK_BL, S_LINK_BLX: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_PC;
                write = 1'b1;
            end
            S_JMP: begin
                load_pc = 1'b1;
                pc_sel  = PC_SEL_C;
            end
`endif
            default: ;
        endcase
    end

endmodule
